// File: rtl/serial_addsub.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per cycle, LSB-first,
// valid/ready on both sides, registered result and status flags.
module serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             sel_in,
    input  logic             abort_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_o,
    output logic             cb_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic             neg_o
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             cb_q, cb_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    logic [DIGIT:0]   slice_sum;
    logic [WIDTH-1:0] acc_next;
    logic             last_digit;

    always_comb begin
        // Operands shift right each RUN cycle; the finished slice enters the accumulator at the top
        slice_sum  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
        acc_next   = (acc_q >> DIGIT) | (WIDTH'(slice_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
        last_digit = (cnt_q == CW'(NDIG - 1));

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cb_d    = cb_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in ^ {WIDTH{sel_in}};
                    carry_d = sel_in;
                    sa_d    = a_in[WIDTH-1];
                    sb_d    = b_in[WIDTH-1] ^ sel_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Abort wins over completion so the visible result stays the last finished one
                if (abort_in) begin
                    state_d = IDLE;
                end else begin
                    a_d     = a_q >> DIGIT;
                    b_d     = b_q >> DIGIT;
                    carry_d = slice_sum[DIGIT];
                    acc_d   = acc_next;
                    cnt_d   = cnt_q + CW'(1);
                    if (last_digit) begin
                        state_d = DONE;
                        res_d   = acc_next;
                        cb_d    = slice_sum[DIGIT];
                        ovf_d   = (sa_q == sb_q) && (acc_next[WIDTH-1] != sa_q);
                        zero_d  = ~|acc_next;
                        neg_d   = acc_next[WIDTH-1];
                    end
                end
            end
            DONE: begin
                if (abort_in || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            cb_q    <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cb_q    <= cb_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign res_o     = res_q;
    assign cb_o      = cb_q;
    assign ovf_o     = ovf_q;
    assign zero_o    = zero_q;
    assign neg_o     = neg_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Drives three serial_addsub instances (DIGIT = 4, 1, 16) in lockstep and checks
// latency, handshakes, abort, reset and results against an arithmetic model.
module tb_serial_addsub;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        sel_in;
    logic        abort_in;
    logic        out_ready;

    logic        in_ready_w  [3];
    logic        out_valid_w [3];
    logic [15:0] res_w       [3];
    logic        cb_w        [3];
    logic        ovf_w       [3];
    logic        zero_w      [3];
    logic        neg_w       [3];

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    int          lat [3]  = '{4, 16, 1};
    logic [19:0] prev [3] = '{20'h0, 20'h0, 20'h0};

    serial_addsub #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .a_in(a_in), .b_in(b_in), .sel_in(sel_in), .abort_in(abort_in),
        .out_valid(out_valid_w[0]), .out_ready(out_ready), .res_o(res_w[0]),
        .cb_o(cb_w[0]), .ovf_o(ovf_w[0]), .zero_o(zero_w[0]), .neg_o(neg_w[0])
    );

    serial_addsub #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .a_in(a_in), .b_in(b_in), .sel_in(sel_in), .abort_in(abort_in),
        .out_valid(out_valid_w[1]), .out_ready(out_ready), .res_o(res_w[1]),
        .cb_o(cb_w[1]), .ovf_o(ovf_w[1]), .zero_o(zero_w[1]), .neg_o(neg_w[1])
    );

    serial_addsub #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[2]),
        .a_in(a_in), .b_in(b_in), .sel_in(sel_in), .abort_in(abort_in),
        .out_valid(out_valid_w[2]), .out_ready(out_ready), .res_o(res_w[2]),
        .cb_o(cb_w[2]), .ovf_o(ovf_w[2]), .zero_o(zero_w[2]), .neg_o(neg_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    // {res, cb, ovf, zero, neg}
    function automatic logic [19:0] obs(input int i);
        return {res_w[i], cb_w[i], ovf_w[i], zero_w[i], neg_w[i]};
    endfunction

    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic [16:0] u;
        logic [15:0] r;
        logic        cb;
        logic        ov;
        int          sr;
        if (s) begin
            u  = {1'b0, a} - {1'b0, b};
            cb = (a >= b);
            sr = int'($signed(a)) - int'($signed(b));
        end else begin
            u  = {1'b0, a} + {1'b0, b};
            cb = u[16];
            sr = int'($signed(a)) + int'($signed(b));
        end
        r  = u[15:0];
        ov = (sr > 32767) || (sr < -32768);
        return {r, cb, ov, (r == 16'h0), r[15]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // Called just after a negedge; returns just after a negedge.
    task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic s, input logic ab);
        logic [19:0] exp;
        exp      = model(a, b, s);
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        sel_in   = s;
        abort_in = ab;
        @(negedge clk);
        abort_in = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            a_in   = 16'($urandom);
            b_in   = 16'($urandom);
            sel_in = 1'($urandom);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk("out_valid", 32'(out_valid_w[i]), 32'(k >= lat[i]));
                chk("in_ready_busy", 32'(in_ready_w[i]), 32'd0);
                chk("result", 32'(obs(i)), 32'((k >= lat[i]) ? exp : prev[i]));
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("out_valid_release", 32'(out_valid_w[i]), 32'd0);
            chk("in_ready_release", 32'(in_ready_w[i]), 32'd1);
            chk("result_hold", 32'(obs(i)), 32'(exp));
            prev[i] = exp;
        end
    endtask

    task automatic abort_txn(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic [19:0] exp;
        exp      = model(a, b, s);
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        sel_in   = s;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        abort_in = 1'b1;
        @(negedge clk);
        abort_in = 1'b0;
        // The DIGIT=16 instance completed on its first edge before the abort landed
        prev[2] = exp;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) begin
                chk("abort_out_valid", 32'(out_valid_w[i]), 32'd0);
                chk("abort_in_ready", 32'(in_ready_w[i]), 32'd1);
                chk("abort_result", 32'(obs(i)), 32'(prev[i]));
            end
            @(negedge clk);
        end
    endtask

    task automatic reset_mid_run(input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        sel_in   = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_mid_result", 32'(obs(i)), 32'd0);
            chk("rst_mid_out_valid", 32'(out_valid_w[i]), 32'd0);
            chk("rst_mid_in_ready", 32'(in_ready_w[i]), 32'd1);
            prev[i] = '0;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        sel_in    = 1'b0;
        abort_in  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_result", 32'(obs(i)), 32'd0);
            chk("reset_in_ready", 32'(in_ready_w[i]), 32'd1);
            chk("reset_out_valid", 32'(out_valid_w[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(16'h1234, 16'h0FFF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) chk("t1_add", 32'(obs(i)), 32'({16'h2233, 4'b0000}));
        run_txn(16'h0005, 16'h0007, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) chk("t2_sub_neg", 32'(obs(i)), 32'({16'hFFFE, 4'b0001}));
        run_txn(16'h00AA, 16'h00AA, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) chk("t2_sub_zero", 32'(obs(i)), 32'({16'h0000, 4'b1010}));
        run_txn(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) chk("t3_add_ovf", 32'(obs(i)), 32'({16'h8000, 4'b0101}));
        run_txn(16'h8000, 16'h0001, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) chk("t3_sub_ovf", 32'(obs(i)), 32'({16'h7FFF, 4'b1100}));

        abort_txn(16'h4321, 16'h1111, 1'b0);
        reset_mid_run(16'hABCD, 16'h1357);
        run_txn(16'hFFFF, 16'h0001, 1'b0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            run_txn(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
